// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and defaults for the pong design
//
// Purpose: state codes and default sizes shared by the sequencer, draw and
//   datapath blocks, so every consumer of the state bus decodes it the same way.
// Contents:
//   state_t       3-bit game state encoding (MENU=0 .. END_GAME=5)
//   PONG_SCORE_W  default width of the score and max-score registers
//   PONG_MAX_DEF  default winning score loaded at reset
package pong_pkg;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_SET       = 3'd1,
    S_START     = 3'd2,
    S_PLAY      = 3'd3,
    S_END_POINT = 3'd4,
    S_END_GAME  = 3'd5
  } state_t;

  localparam int PONG_SCORE_W = 5;
  localparam int PONG_MAX_DEF = 5;

endpackage

// File: rtl/btn_edge_frame.sv
// rtl/btn_edge_frame.sv - once-per-frame rising-edge detector for a button level
//
// Purpose: turns an already synchronised button level into a single-cycle press
//   pulse. The level is only looked at on frame_tick, so at most one press per
//   frame is possible and a held button fires exactly once.
// Ports:
//   clk_pix     in  pixel clock, posedge
//   reset       in  synchronous, active-high
//   frame_tick  in  one-cycle pulse per frame
//   level       in  button level
//   press       out high for the frame_tick cycle on which a new press is seen
module btn_edge_frame (
  input  logic clk_pix,
  input  logic reset,
  input  logic frame_tick,
  input  logic level,
  output logic press
);

  logic prev;

  // prev starts at 1 so a button held through reset needs a release first.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      prev <= 1'b1;
    end else if (frame_tick) begin
      prev <= level;
    end
  end

  // Combinational so the consuming FSM acts on the same edge as frame_tick.
  assign press = frame_tick & level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - pong game-flow FSM, scores, max-score setting and serve side
//
// Purpose: runs MENU/SET/START/PLAY/END_POINT/END_GAME, parks or animates the
//   ball datapath through ball_reset/play_en, and owns the scores, the
//   max-score setting and which paddle serves next.
// Ports:
//   clk_pix, reset            pixel clock; synchronous active-high reset
//   frame_tick                one-cycle pulse per frame; buttons and hold timer step on it
//   btn_launch/btn_up/btn_down synchronised button levels
//   left_hit/right_hit        ball reached left/right wall, read only in PLAY
//   state                     current state code (pong_pkg::state_t)
//   menu_sel                  menu cursor: 0 = PLAY, 1 = SET-SCORE
//   max_score                 winning score
//   score_p1/score_p2         left/right player scores
//   serve_p2                  0 = serve from left paddle, 1 = from right paddle
//   ball_reset/play_en        high in START / PLAY respectively
//   game_over                 high in END_GAME
module game_sequencer
  import pong_pkg::*;
#(
  parameter int SCORE_W     = PONG_SCORE_W,
  parameter int MAX_DEF     = PONG_MAX_DEF,
  parameter int MAX_MIN     = 1,
  parameter int MAX_MAX     = 15,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_launch,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               left_hit,
  input  logic               right_hit,
  output logic [2:0]         state,
  output logic               menu_sel,
  output logic [SCORE_W-1:0] max_score,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_p2,
  output logic               ball_reset,
  output logic               play_en,
  output logic               game_over
);

  localparam int                 HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SET_MAX   = SCORE_W'(MAX_MAX);
  localparam logic [SCORE_W-1:0] SET_MIN   = SCORE_W'(MAX_MIN);

  state_t            state_r;
  state_t            state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              launch_press;
  logic              up_press;
  logic              down_press;
  logic              game_won;

  btn_edge_frame u_btn_launch (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .frame_tick (frame_tick),
    .level      (btn_launch),
    .press      (launch_press)
  );

  btn_edge_frame u_btn_up (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .frame_tick (frame_tick),
    .level      (btn_up),
    .press      (up_press)
  );

  btn_edge_frame u_btn_down (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .frame_tick (frame_tick),
    .level      (btn_down),
    .press      (down_press)
  );

  // Scores are already updated on entry to END_POINT, so this sees the new point.
  assign game_won = (score_p1 >= max_score) || (score_p2 >= max_score);

  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_MENU:      if (launch_press) state_nx = menu_sel ? S_SET : S_START;
      S_SET:       if (launch_press) state_nx = S_MENU;
      S_START:     if (launch_press) state_nx = S_PLAY;
      S_PLAY:      if (left_hit || right_hit) state_nx = S_END_POINT;
      S_END_POINT: if (frame_tick && hold_cnt == HOLD_LAST)
                     state_nx = game_won ? S_END_GAME : S_START;
      S_END_GAME:  if (launch_press) state_nx = S_MENU;
      default:     state_nx = S_MENU;
    endcase
  end

  // The decoded strobes are registered from state_nx so they line up exactly
  // with the registered state.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_r    <= S_MENU;
      menu_sel   <= 1'b0;
      max_score  <= SCORE_W'(MAX_DEF);
      score_p1   <= '0;
      score_p2   <= '0;
      serve_p2   <= 1'b0;
      hold_cnt   <= '0;
      ball_reset <= 1'b0;
      play_en    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_r    <= state_nx;
      ball_reset <= (state_nx == S_START);
      play_en    <= (state_nx == S_PLAY);
      game_over  <= (state_nx == S_END_GAME);

      case (state_r)
        S_MENU: begin
          // Launch wins over a cursor move landing in the same frame.
          if (launch_press) begin
            if (!menu_sel) begin
              score_p1 <= '0;
              score_p2 <= '0;
            end
          end else if (up_press || down_press) begin
            menu_sel <= ~menu_sel;
          end
        end

        S_SET: begin
          if (up_press && !down_press && max_score < SET_MAX) begin
            max_score <= max_score + 1'b1;
          end else if (down_press && !up_press && max_score > SET_MIN) begin
            max_score <= max_score - 1'b1;
          end
        end

        S_PLAY: begin
          // Clearing here means the count is zero on every entry to END_POINT.
          hold_cnt <= '0;
          if (right_hit && !left_hit) begin
            if (score_p1 != SCORE_TOP) score_p1 <= score_p1 + 1'b1;
            serve_p2 <= 1'b1;
          end else if (left_hit && !right_hit) begin
            if (score_p2 != SCORE_TOP) score_p2 <= score_p2 + 1'b1;
            serve_p2 <= 1'b0;
          end
        end

        S_END_POINT: begin
          if (frame_tick) hold_cnt <= hold_cnt + 1'b1;
        end

        S_END_GAME: begin
          if (launch_press) menu_sel <= 1'b0;
        end

        default: ;
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

  logic       clk_pix = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_launch;
  logic       btn_up;
  logic       btn_down;
  logic       left_hit;
  logic       right_hit;
  logic [2:0] state;
  logic       menu_sel;
  logic [4:0] max_score;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic       serve_p2;
  logic       ball_reset;
  logic       play_en;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_pix = ~clk_pix;

  game_sequencer dut (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_launch (btn_launch),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .left_hit   (left_hit),
    .right_hit  (right_hit),
    .state      (state),
    .menu_sel   (menu_sel),
    .max_score  (max_score),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve_p2   (serve_p2),
    .ball_reset (ball_reset),
    .play_en    (play_en),
    .game_over  (game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic frame();
    @(negedge clk_pix) frame_tick = 1'b1;
    @(negedge clk_pix) frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press(input bit l, input bit u, input bit d);
    btn_launch = l;
    btn_up     = u;
    btn_down   = d;
    frame();
    btn_launch = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    frame();
  endtask

  task automatic hit(input bit l, input bit r);
    @(negedge clk_pix);
    left_hit  = l;
    right_hit = r;
    @(negedge clk_pix);
    left_hit  = 1'b0;
    right_hit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    btn_launch = 1'b1;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    left_hit   = 1'b0;
    right_hit  = 1'b0;
    repeat (3) @(negedge clk_pix);
    reset = 1'b0;
    @(negedge clk_pix);

    // Reset state, launch held through reset.
    check("rst_state", state, 0);
    check("rst_menu_sel", menu_sel, 0);
    check("rst_max", max_score, 5);
    check("rst_p1", score_p1, 0);
    check("rst_p2", score_p2, 0);
    check("rst_serve", serve_p2, 0);
    check("rst_ball_reset", ball_reset, 0);
    check("rst_play_en", play_en, 0);
    check("rst_game_over", game_over, 0);
    frame();
    check("held_launch_no_fire", state, 0);
    btn_launch = 1'b0;
    frame();
    press(1, 0, 0);
    check("menu_to_start", state, 2);
    check("start_ball_reset", ball_reset, 1);
    check("start_p1", score_p1, 0);

    // Hits ignored in START.
    hit(1, 0);
    check("start_hit_state", state, 2);
    check("start_hit_p2", score_p2, 0);

    // PLAY, right hit, hold timing.
    press(1, 0, 0);
    check("play_state", state, 3);
    check("play_en", play_en, 1);
    check("play_ball_reset", ball_reset, 0);
    hit(0, 1);
    check("rhit_state", state, 4);
    check("rhit_p1", score_p1, 1);
    check("rhit_serve", serve_p2, 1);
    check("rhit_play_en", play_en, 0);
    frames(59);
    check("hold_59", state, 4);
    frame();
    check("hold_60", state, 2);
    check("hold_ball_reset", ball_reset, 1);

    // Second point for p1.
    press(1, 0, 0);
    hit(0, 1);
    check("rhit2_p1", score_p1, 2);
    frames(60);
    check("rhit2_back_start", state, 2);

    // Simultaneous hits.
    press(1, 0, 0);
    hit(1, 1);
    check("both_state", state, 4);
    check("both_p1", score_p1, 2);
    check("both_p2", score_p2, 0);
    check("both_serve", serve_p2, 1);
    frames(60);
    check("both_back_start", state, 2);

    // Third point, then reset mid END_POINT.
    press(1, 0, 0);
    hit(0, 1);
    check("rhit3_p1", score_p1, 3);
    frames(5);
    check("ep_mid_state", state, 4);
    @(negedge clk_pix) reset = 1'b1;
    @(negedge clk_pix) reset = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_p1", score_p1, 0);
    check("mid_rst_max", max_score, 5);
    check("mid_rst_serve", serve_p2, 0);
    frame();

    // MENU cursor and SET saturation.
    press(0, 0, 1);
    check("menu_down_sel", menu_sel, 1);
    press(1, 0, 0);
    check("to_set", state, 1);
    for (int i = 0; i < 20; i++) press(0, 1, 0);
    check("max_sat_hi", max_score, 15);
    for (int i = 0; i < 20; i++) press(0, 0, 1);
    check("max_sat_lo", max_score, 1);
    press(0, 1, 0);
    check("max_up_2", max_score, 2);
    press(0, 1, 1);
    check("max_up_down_same", max_score, 2);
    press(1, 0, 0);
    check("set_to_menu", state, 0);
    press(0, 1, 0);
    check("menu_up_sel", menu_sel, 0);
    press(1, 0, 0);
    check("menu_to_start2", state, 2);

    // Game to max_score=2 via left hits.
    press(1, 0, 0);
    hit(1, 0);
    check("lhit_p2", score_p2, 1);
    check("lhit_serve", serve_p2, 0);
    frames(60);
    check("lhit_not_won", state, 2);
    press(1, 0, 0);
    hit(1, 0);
    check("lhit2_p2", score_p2, 2);
    frames(60);
    check("end_game_state", state, 5);
    check("game_over", game_over, 1);
    check("end_game_p2_held", score_p2, 2);
    press(1, 0, 0);
    check("end_to_menu", state, 0);
    check("end_menu_sel", menu_sel, 0);
    check("end_menu_game_over", game_over, 0);
    press(1, 0, 0);
    check("new_start_state", state, 2);
    check("new_start_p1", score_p1, 0);
    check("new_start_p2", score_p2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
